// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Boot-time instruction-memory writer. Consumes a byte stream
//               (16-bit big-endian word count, then 4 bytes per word, MSB
//               first), assembles 32-bit words and writes them to consecutive
//               word addresses starting at BASE_ADDR. Holds the CPU core in
//               reset via cpu_hold while a load is in progress.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous active-low reset
//               start     - one-cycle pulse, begins a load (IDLE only)
//               in_valid  - in_data holds a byte
//               in_data   - stream byte
//               in_ready  - loader accepts a byte this cycle
//               im_we     - instruction-memory write strobe
//               im_addr   - word-aligned byte address of the write
//               im_wdata  - instruction word
//               cpu_hold  - keep core (PC/fetch) in reset
//               done      - one-cycle pulse at end of load
//               err       - sticky: last header count was illegal
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
    parameter int          DEPTH_WORDS = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] shift;

    logic        accept;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        last_write;

    assign accept    = in_valid & in_ready;
    assign hdr_count = {count[15:8], in_data};
    assign hdr_bad   = (hdr_count == 16'd0) ||
                       ({1'b0, hdr_count} > 17'(DEPTH_WORDS));
    // word_idx has already advanced past the word being written, so it
    // equals count exactly during the write cycle of the final word.
    assign last_write = im_we && (word_idx == count);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        unique case (state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (start) next_state = HDR0;
            end
            HDR0: begin
                in_ready = 1'b1;
                if (accept) next_state = HDR1;
            end
            HDR1: begin
                in_ready = 1'b1;
                if (accept) next_state = hdr_bad ? DONE : DATA;
            end
            DATA: begin
                // Ready stays high through the write cycle to sustain one
                // byte per clock across word boundaries.
                in_ready = 1'b1;
                if (last_write) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header capture, word assembly, memory write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            shift    <= 24'd0;
            im_we    <= 1'b0;
            im_addr  <= 32'd0;
            im_wdata <= 32'd0;
            err      <= 1'b0;
        end else begin
            im_we <= 1'b0;

            if ((state == IDLE) && start) begin
                err      <= 1'b0;
                count    <= 16'd0;
                word_idx <= 16'd0;
                byte_idx <= 2'd0;
            end

            if (accept) begin
                unique case (state)
                    HDR0: begin
                        count[15:8] <= in_data;
                    end
                    HDR1: begin
                        count[7:0] <= in_data;
                        if (hdr_bad) err <= 1'b1;
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        shift    <= {shift[15:0], in_data};
                        if (byte_idx == 2'd3) begin
                            im_we    <= 1'b1;
                            im_wdata <= {shift, in_data};
                            im_addr  <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            word_idx <= word_idx + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Self-checking bench for im_loader. Expected writes are queued
//               as words are driven and compared as the DUT writes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    localparam logic [31:0] BASE = 32'h0000_3000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int          n_checks;
    int          n_errors;
    int          we_cnt;
    int          done_cnt;
    logic [31:0] last_addr;
    logic [63:0] exp_q[$];
    logic [31:0] words[0:2047];

    im_loader #(
        .BASE_ADDR   (32'h0000_3000),
        .DEPTH_WORDS (2048)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (im_we) begin
                we_cnt++;
                last_addr = im_addr;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_we", 32'd1, 32'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check_eq("im_addr", im_addr, e[63:32]);
                    check_eq("im_wdata", im_wdata, e[31:0]);
                end
            end
            if (done) done_cnt++;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            in_valid = 1'b0;
            in_data  = 8'hFF;
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("start_hold", {31'd0, cpu_hold}, 32'd1);
        check_eq("start_ready", {31'd0, in_ready}, 32'd1);
        check_eq("start_err_clr", {31'd0, err}, 32'd0);
    endtask

    function automatic int pick_gap(input bit gapped);
        return gapped ? int'($urandom_range(0, 3)) : 0;
    endfunction

    task automatic load(input int n, input logic [15:0] hdr,
                        input bit gapped, input bit spur);
        int we0;
        int dn0;
        we0 = we_cnt;
        dn0 = done_cnt;
        do_start();
        send_byte(hdr[15:8], pick_gap(gapped));
        send_byte(hdr[7:0], pick_gap(gapped));
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = words[i];
            exp_q.push_back({BASE + 32'(4 * i), w});
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8], pick_gap(gapped));
            end
            if (spur && i == 0 && n > 1) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check_eq("spur_hold", {31'd0, cpu_hold}, 32'd1);
                check_eq("spur_ready", {31'd0, in_ready}, 32'd1);
            end
        end
        // Last byte accepted at edge m; now in cycle m+1.
        @(negedge clk);
        check_eq("last_we", {31'd0, im_we}, 32'd1);
        check_eq("done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("hold_in_done", {31'd0, cpu_hold}, 32'd1);
        check_eq("err_ok", {31'd0, err}, 32'd0);
        @(negedge clk);
        check_eq("done_end", {31'd0, done}, 32'd0);
        check_eq("hold_end", {31'd0, cpu_hold}, 32'd0);
        #2;
        check_eq("we_count", 32'(we_cnt - we0), 32'(n));
        check_eq("done_count", 32'(done_cnt - dn0), 32'd1);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic load_bad(input logic [15:0] hdr);
        int we0;
        we0 = we_cnt;
        do_start();
        send_byte(hdr[15:8], 0);
        send_byte(hdr[7:0], 0);
        @(negedge clk);
        check_eq("bad_done", {31'd0, done}, 32'd1);
        check_eq("bad_err", {31'd0, err}, 32'd1);
        check_eq("bad_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check_eq("bad_done_end", {31'd0, done}, 32'd0);
        check_eq("bad_hold_end", {31'd0, cpu_hold}, 32'd0);
        check_eq("bad_err_sticky", {31'd0, err}, 32'd1);
        #2;
        check_eq("bad_no_we", 32'(we_cnt - we0), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        we_cnt    = 0;
        done_cnt  = 0;
        last_addr = 32'd0;
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_im_we", {31'd0, im_we}, 32'd0);
        check_eq("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_im_addr", im_addr, 32'd0);
        check_eq("rst_im_wdata", im_wdata, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Nominal full-rate load
        words[0] = 32'h2408_0005;
        words[1] = 32'h3409_000C;
        load(2, 16'h0002, 1'b0, 1'b0);

        // Gapped stream with the same data
        load(2, 16'h0002, 1'b1, 1'b0);

        // Illegal headers
        load_bad(16'h0000);
        load_bad(16'h0801);

        // in_valid in IDLE is ignored
        begin
            int we0;
            we0 = we_cnt;
            in_valid = 1'b1;
            in_data  = 8'hA5;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check_eq("idle_ready", {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
            #2;
            check_eq("idle_no_we", 32'(we_cnt - we0), 32'd0);
            @(posedge clk);
            #1;
        end

        // Spurious start during DATA, random data
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        load(4, 16'h0004, 1'b1, 1'b1);

        // Reset mid-load after 1.5 words
        begin
            int we0;
            we0 = we_cnt;
            for (int i = 0; i < 4; i++) words[i] = $urandom;
            do_start();
            send_byte(8'h00, 0);
            send_byte(8'h04, 0);
            exp_q.push_back({BASE, words[0]});
            for (int b = 0; b < 4; b++) send_byte(words[0][31 - 8*b -: 8], 0);
            send_byte(words[1][31:24], 0);
            send_byte(words[1][23:16], 0);
            reset = 1'b0;
            #1;
            check_eq("abort_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("abort_im_we", {31'd0, im_we}, 32'd0);
            check_eq("abort_cpu_hold", {31'd0, cpu_hold}, 32'd0);
            check_eq("abort_done", {31'd0, done}, 32'd0);
            check_eq("abort_err", {31'd0, err}, 32'd0);
            check_eq("abort_im_addr", im_addr, 32'd0);
            check_eq("abort_im_wdata", im_wdata, 32'd0);
            check_eq("abort_we_count", 32'(we_cnt - we0), 32'd1);
            check_eq("abort_queue", 32'(exp_q.size()), 32'd0);
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) words[i] = $urandom;
            load(4, 16'h0004, 1'b0, 1'b0);
        end

        // Maximum count
        for (int i = 0; i < 2048; i++) words[i] = $urandom;
        load(2048, 16'h0800, 1'b0, 1'b0);
        check_eq("max_last_addr", last_addr, 32'h0000_4FFC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/im_loader.md
# im_loader

Boot-time instruction-memory writer: the writing end of the instruction store that the fetch unit reads. It receives a byte stream (2-byte big-endian word count, then 4 bytes per instruction, MSB first), assembles 32-bit words and writes them into instruction memory at consecutive word addresses starting at the text base 0x3000. While a load is in progress it holds the CPU core off via `cpu_hold`, so fetch never sees a half-written program.

## Interface
- `BASE_ADDR`, 32'h0000_3000: byte address written for word 0.
- `DEPTH_WORDS`, 2048: instruction memory capacity in words; maximum legal count.

- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr`  out  32  byte address of the write, word aligned.
- `im_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keep the core (PC/fetch) in reset.
- `done`  out  1  one-cycle pulse at end of load (success or error).
- `err`  out  1  sticky: last header count was illegal.

## Operation
- Byte transfer occurs at a rising edge with `in_valid & in_ready`; no other byte is consumed.
- States: IDLE, HDR0, HDR1, DATA, DONE.
- IDLE: `in_ready`=0. `start` -> HDR0; set `cpu_hold`=1, clear `err`, clear word index and byte index.
- HDR0: `in_ready`=1; accepted byte -> count[15:8]; -> HDR1.
- HDR1: `in_ready`=1; accepted byte -> count[7:0]. If the full 16-bit count is 0 or greater than `DEPTH_WORDS`: set `err`=1 -> DONE with no writes. Otherwise -> DATA.
- DATA: `in_ready`=1; bytes shift into a 32-bit assembler, the first byte landing in [31:24]. The byte index counts 0..3 and wraps.
- On acceptance of byte index 3, a write is registered for the next cycle:
  - `im_we`=1.
  - `im_wdata` = assembled word.
  - `im_addr` = `BASE_ADDR` + 4*word_index, computed as a 32-bit sum with wrap ignored.
  - The word index then increments.
- The write of word count-1 moves to DONE, in the same cycle that `im_we` is high.
- DONE: `in_ready`=0; `done`=1 for exactly one cycle; `cpu_hold` deasserts on leaving DONE; -> IDLE.
- `start` outside IDLE is ignored. `in_valid` in IDLE/DONE is ignored and no byte is consumed.
- `err` holds until the next accepted `start` or reset.
- Bytes between words may arrive with any gap. `in_ready` stays high during the write cycle, so back-to-back streaming at one byte per clock is sustained.

## Timing
- Reset (`reset`=0, async):
  - State -> IDLE.
  - `in_ready`, `im_we`, `cpu_hold`, `done`, `err` = 0.
  - `im_addr`, `im_wdata` = 0.
  - Counters = 0.
- Reset release is synchronous to `clk`.
- Reset mid-load aborts immediately: no further writes, `cpu_hold` drops. Words already written are left in memory. No `done` pulse.
- `start` at edge k -> `cpu_hold`=1 and `in_ready`=1 after edge k.
- Write latency: `im_we` is high in the cycle following the edge that accepted the 4th byte of a word.
- Timing of `done` after the last data byte:
  - Last data byte accepted at edge m -> `im_we` high in cycle m+1.
  - State is DONE after edge m+1, so `done` is high in cycle m+2.
  - `cpu_hold` is 0 from cycle m+3.
- Illegal count accepted at edge h -> `done` high in cycle h+1, with `err`=1 from the same cycle.
- Minimum load time for N words at full rate: 2 + 4N + 2 cycles from `start` to `done` deassertion.

## Test plan
- Nominal load: `start`, then bytes 00 02 | 24 08 00 05 | 34 09 00 0C at one byte per clock.
  - Required: two writes, (0x3000, 0x24080005) then (0x3004, 0x3409000C).
  - Required: one `done` pulse, `err`=0.
  - Required: `cpu_hold` high from `start` through DONE.
- Gapped stream: same data with `in_valid` toggling 1/0 and random 0-3 cycle gaps.
  - Required: identical writes and `done`.
  - Required: no byte consumed while `in_valid`=0.
- Illegal count:
  - Header 00 00 -> `err`=1, `done` pulse, zero `im_we`.
  - Header 08 01 (2049 > 2048) -> same.
- Maximum count: header 08 00 with 2048 words.
  - Required: last write at `im_addr`=0x4FFC, then `done`.
- Reset mid-load: assert `reset`=0 after 1.5 words of a 4-word load.
  - Required: all outputs 0 immediately, only word 0 was written.
  - Required: a subsequent full load completes correctly.
- Spurious control:
  - `start` pulsed during DATA -> no effect on counts or addresses.
  - `in_valid`=1 in IDLE -> `in_ready`=0, nothing written.
